// File: rtl/sseg_scan_decoder_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
package sseg_scan_decoder_pkg;

  localparam int unsigned BCD_W = 12;
  localparam int unsigned BIN_W = 10;

  // Digit strobe indices within digits_in
  localparam int unsigned DIG_ONES     = 0;
  localparam int unsigned DIG_TENS     = 1;
  localparam int unsigned DIG_HUNDREDS = 2;

  // Active-low segment patterns, bits 6:0 = g..a
  localparam logic [6:0] SSEG_0 = 7'h40;
  localparam logic [6:0] SSEG_1 = 7'h79;
  localparam logic [6:0] SSEG_2 = 7'h24;
  localparam logic [6:0] SSEG_3 = 7'h30;
  localparam logic [6:0] SSEG_4 = 7'h19;
  localparam logic [6:0] SSEG_5 = 7'h12;
  localparam logic [6:0] SSEG_6 = 7'h02;
  localparam logic [6:0] SSEG_7 = 7'h78;
  localparam logic [6:0] SSEG_8 = 7'h00;
  localparam logic [6:0] SSEG_9 = 7'h10;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StConvert = 2'd1,
    StDone    = 2'd2
  } conv_state_e;

  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } digit_t;

  // Unknown patterns decode to 0 with the error bit set
  function automatic digit_t decode_sseg(input logic [6:0] seg);
    digit_t d;
    d.err    = 1'b0;
    d.nibble = 4'd0;
    case (seg)
      SSEG_0:  d.nibble = 4'd0;
      SSEG_1:  d.nibble = 4'd1;
      SSEG_2:  d.nibble = 4'd2;
      SSEG_3:  d.nibble = 4'd3;
      SSEG_4:  d.nibble = 4'd4;
      SSEG_5:  d.nibble = 4'd5;
      SSEG_6:  d.nibble = 4'd6;
      SSEG_7:  d.nibble = 4'd7;
      SSEG_8:  d.nibble = 4'd8;
      SSEG_9:  d.nibble = 4'd9;
      default: d.err    = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sseg_scan_decoder_bcd_to_bin_seq.sv
// Sequential reverse double-dabble: 3-digit BCD to 10-bit binary in 10 shift cycles.
module bcd_to_bin_seq
  import sseg_scan_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BCD_W-1:0] bcd_in,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] bin_out
);

  localparam int unsigned WORK_W    = BCD_W + BIN_W;
  localparam logic [3:0]  LAST_ITER = 4'(BIN_W - 1);

  conv_state_e       state_q, state_d;
  logic [WORK_W-1:0] work_q, work_d, adj;
  logic [3:0]        iter_q, iter_d;

  // One iteration: shift right, then pull 3 out of every BCD nibble that is >= 8
  always_comb begin
    adj = work_q >> 1;
    for (int i = 0; i < 3; i++) begin
      if (adj[BIN_W + 4*i +: 4] >= 4'd8) begin
        adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    iter_d  = iter_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = {bcd_in, {BIN_W{1'b0}}};
          iter_d  = 4'd0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        work_d = adj;
        iter_d = iter_q + 4'd1;
        if (iter_q == LAST_ITER) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and work register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      iter_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      iter_q  <= iter_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign bin_out = work_q[BIN_W-1:0];

endmodule

// File: rtl/sseg_scan_decoder.sv
// Recovers the 3-digit value shown on a scanned seven-segment display.
module sseg_scan_decoder
  import sseg_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sseg_in,
  input  logic [3:0] digits_in,
  output logic [9:0] address_value,
  output logic       value_valid,
  output logic       pattern_error,
  output logic       range_overflow
);

  localparam logic [3:0] CAP_COUNT = 4'(STABLE_CYCLES - 1);

  logic [11:0]      sample, prev_q;
  logic [3:0]       cnt_q, cnt_d;
  logic             held_q, held_d;
  logic             same, strobe_ok, capture;
  digit_t           dec;

  logic [2:0][3:0]  slot_q, slot_d;
  logic [2:0]       err_q, err_d, mask_q, mask_d;
  logic [BCD_W-1:0] pend_bcd_q, pend_bcd_d;
  logic             pend_err_q, pend_err_d;
  logic             frame_ready_q, frame_ready_d;
  logic             conv_err_q, conv_err_d;

  logic             start, busy, done;
  logic [BIN_W-1:0] bin;

  logic [9:0]       addr_q;
  logic             valid_q, perr_q, ovf_q;

  assign sample = {digits_in, sseg_in};
  assign dec    = decode_sseg(sseg_in[6:0]);

  // Stability filter: one capture per stable run of a qualified strobe/segment pair
  always_comb begin
    same      = (sample == prev_q);
    cnt_d     = !same ? 4'd0 : ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1);
    strobe_ok = !digits_in[3] && (digits_in[2:0] inside {3'b001, 3'b010, 3'b100});
    capture   = same && !held_q && (cnt_d == CAP_COUNT) && strobe_ok;
    held_d    = same && (held_q || (cnt_d == CAP_COUNT));
  end

  // Frame assembly and hand-off of completed frames to the converter
  always_comb begin
    slot_d        = slot_q;
    err_d         = err_q;
    mask_d        = mask_q;
    pend_bcd_d    = pend_bcd_q;
    pend_err_d    = pend_err_q;
    start         = frame_ready_q && !busy;
    frame_ready_d = frame_ready_q && !start;
    conv_err_d    = start ? pend_err_q : conv_err_q;
    if (capture) begin
      for (int i = 0; i < 3; i++) begin
        if (digits_in[i]) begin
          slot_d[i] = dec.nibble;
          err_d[i]  = dec.err;
        end
      end
      mask_d = mask_q | digits_in[2:0];
      if (mask_d == 3'b111) begin
        // A newer frame replaces one still waiting for the converter
        pend_bcd_d    = slot_d;
        pend_err_d    = |err_d;
        frame_ready_d = 1'b1;
        mask_d        = 3'b000;
      end
    end
  end

  // Filter and frame registers
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q        <= '0;
      cnt_q         <= 4'd0;
      held_q        <= 1'b0;
      slot_q        <= '0;
      err_q         <= '0;
      mask_q        <= '0;
      pend_bcd_q    <= '0;
      pend_err_q    <= 1'b0;
      frame_ready_q <= 1'b0;
      conv_err_q    <= 1'b0;
    end else begin
      prev_q        <= sample;
      cnt_q         <= cnt_d;
      held_q        <= held_d;
      slot_q        <= slot_d;
      err_q         <= err_d;
      mask_q        <= mask_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_err_q    <= pend_err_d;
      frame_ready_q <= frame_ready_d;
      conv_err_q    <= conv_err_d;
    end
  end

  bcd_to_bin_seq u_conv (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bcd_in  (pend_bcd_q),
    .busy    (busy),
    .done    (done),
    .bin_out (bin)
  );

  // Output registers, updated only when a conversion finishes
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= done;
      if (done) begin
        addr_q <= bin;
        perr_q <= conv_err_q;
        ovf_q  <= (bin > 10'd511);
      end
    end
  end

  assign address_value  = addr_q;
  assign value_valid    = valid_q;
  assign pattern_error  = perr_q;
  assign range_overflow = ovf_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder.
module tb_sseg_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sseg_in;
  logic [3:0] digits_in;
  logic [9:0] address_value;
  logic       value_valid, pattern_error, range_overflow;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned t;
    logic [9:0]  a;
    logic        pe;
    logic        ov;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;

  sseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .sseg_in        (sseg_in),
    .digits_in      (digits_in),
    .address_value  (address_value),
    .value_valid    (value_valid),
    .pattern_error  (pattern_error),
    .range_overflow (range_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse with the edge count it followed
  always @(negedge clk) begin
    if (value_valid === 1'b1) begin
      mon_e.t  = cyc;
      mon_e.a  = address_value;
      mon_e.pe = pattern_error;
      mon_e.ov = range_overflow;
      evq.push_back(mon_e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    digits_in = d;
    sseg_in   = s;
    repeat (n) @(negedge clk);
  endtask

  // Scans ones, tens, hundreds; hstart is the first edge sampling the hundreds digit
  task automatic scan(input logic [7:0] o, input logic [7:0] t, input logic [7:0] h,
                      input int n, output int unsigned hstart);
    hold(4'b0001, o, n);
    hold(4'b0010, t, n);
    hstart = cyc + 1;
    hold(4'b0100, h, n);
  endtask

  task automatic expect_event(input string tag, input logic [9:0] a, input logic pe,
                              input logic ov, input int unsigned t);
    int n;
    ev_t e;
    n = 0;
    while (evq.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, evq.size() != 0, 1);
    if (evq.size() != 0) begin
      e = evq.pop_front();
      check({tag, "_addr"}, e.a, a);
      check({tag, "_perr"}, e.pe, pe);
      check({tag, "_ovf"}, e.ov, ov);
      check({tag, "_time"}, e.t, t);
    end
  endtask

  initial begin
    int unsigned hs, hs2;
    reset     = 1'b1;
    digits_in = 4'b0000;
    sseg_in   = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_addr", address_value, 0);
    check("rst_valid", value_valid, 0);
    check("rst_perr", pattern_error, 0);
    check("rst_ovf", range_overflow, 0);
    reset = 1'b0;
    hold(4'b0000, 8'hFF, 2);

    // 1, 2, 4 -> 421 with fixed latency and a single pulse
    scan(8'hF9, 8'hA4, 8'h99, 8, hs);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t421", 10'd421, 1'b0, 1'b0, hs + 15);
    hold(4'b0000, 8'hFF, 20);
    check("t421_hold", address_value, 421);
    check("t421_single", evq.size(), 0);

    // 999 overflows a 9-bit address; 511 is the largest that fits
    scan(8'h90, 8'h90, 8'h90, 8, hs);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t999", 10'd999, 1'b0, 1'b1, hs + 15);
    scan(8'hF9, 8'hF9, 8'h92, 8, hs);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t511", 10'd511, 1'b0, 1'b0, hs + 15);

    // Short glitches, multi-hot and bit3 strobes must not be captured
    hold(4'b0001, 8'hF9, 8);
    hold(4'b0100, 8'h80, 2);
    hold(4'b0010, 8'hA4, 8);
    hold(4'b0100, 8'h80, 2);
    hold(4'b0011, 8'hC0, 8);
    hold(4'b1000, 8'hC0, 8);
    hs = cyc + 1;
    hold(4'b0100, 8'hB0, 8);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t321", 10'd321, 1'b0, 1'b0, hs + 15);
    hold(4'b0000, 8'hFF, 20);
    check("t321_nocap", evq.size(), 0);

    // Undecodable tens pattern
    scan(8'hF8, 8'hFF, 8'hB0, 8, hs);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t307", 10'd307, 1'b1, 1'b0, hs + 15);

    // Reset in the middle of a conversion discards it
    scan(8'hF9, 8'hA4, 8'h99, 8, hs);
    reset     = 1'b1;
    digits_in = 4'b0000;
    sseg_in   = 8'hFF;
    repeat (2) @(negedge clk);
    check("trst_addr", address_value, 0);
    check("trst_valid", value_valid, 0);
    check("trst_perr", pattern_error, 0);
    check("trst_ovf", range_overflow, 0);
    reset = 1'b0;
    hold(4'b0000, 8'hFF, 20);
    check("trst_noemit", evq.size(), 0);
    scan(8'hA4, 8'hF9, 8'hC0, 8, hs);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t012", 10'd12, 1'b0, 1'b0, hs + 15);

    // Second frame completes while the first converts; dp differences are ignored
    scan(8'hC0, 8'hC0, 8'hF9, 4, hs);
    scan(8'h40, 8'hC0, 8'h24, 4, hs2);
    hold(4'b0000, 8'hFF, 1);
    expect_event("t100", 10'd100, 1'b0, 1'b0, hs + 15);
    expect_event("t200", 10'd200, 1'b0, 1'b0, hs2 + 15);
    hold(4'b0000, 8'hFF, 20);
    check("t200_noextra", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
